reg_write_sink: RTL and testbench

REG_WRITE_SINK -- requirements
Module: reg_write_sink

---
 rtl/reg_write_sink.sv | 83 ++++++++
 tb/tb_reg_write_sink.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_write_sink.sv
// reg_write_sink: queued register writes to a downstream device, with a shadow
// register file, readback port and sticky interrupt vector.
module reg_write_sink #(
   parameter int FIFO_DEPTH = 4,
   parameter int INT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           in_reg_addr,
   input  logic [31:0]          in_reg_data,
   input  logic                 in_reg_stb,
   output logic                 in_reg_busy,
   input  logic [INT_WIDTH-1:0] in_clear_ints,
   input  logic [INT_WIDTH-1:0] int_set,
   output logic [INT_WIDTH-1:0] pending_ints,
   output logic [5:0]           dev_addr,
   output logic [31:0]          dev_data,
   output logic                 dev_valid,
   input  logic                 dev_ready,
   input  logic [5:0]           rd_addr,
   output logic [31:0]          rd_data,
   output logic                 overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {S_EMPTY, S_PRESENT} state_t;
   state_t state_q, state_d;
   logic [37:0] mem_q [FIFO_DEPTH];
   logic [31:0] shadow_q [64];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic [5:0] dev_addr_q;
   logic [31:0] dev_data_q, rd_data_q;
   logic [INT_WIDTH-1:0] pend_q, pend_d;
   logic busy_q, busy_d, overflow_q, push, pop;
   logic [37:0] head_d;
   always_comb begin
      pop      = (state_q == S_PRESENT) && dev_ready;
      push     = in_reg_stb && !busy_q;
      count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      state_d  = (count_d != '0) ? S_PRESENT : S_EMPTY;
      busy_d   = count_d == (AW+1)'(FIFO_DEPTH);
      // queue drains to empty this edge: the incoming write becomes head directly
      head_d   = (count_q == {{AW{1'b0}}, pop}) ? {in_reg_addr, in_reg_data} : mem_q[rd_ptr_d];
      pend_d   = (pend_q & ~in_clear_ints) | int_set;
      pend_d[INT_WIDTH-1] = (count_d == '0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_EMPTY;
         dev_addr_q <= '0;
         dev_data_q <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         pend_q     <= {1'b1, {(INT_WIDTH-1){1'b0}}};
         rd_data_q  <= '0;
         for (int i = 0; i < 64; i++) shadow_q[i] <= '0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= {in_reg_addr, in_reg_data};
         if (pop) shadow_q[dev_addr_q] <= dev_data_q;
         if (state_d == S_PRESENT) {dev_addr_q, dev_data_q} <= head_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_q | (in_reg_stb && busy_q);
         pend_q     <= pend_d;
         rd_data_q  <= shadow_q[rd_addr];
      end
   end
   assign in_reg_busy  = busy_q;
   assign dev_valid    = (state_q == S_PRESENT);
   assign dev_addr     = dev_addr_q;
   assign dev_data     = dev_data_q;
   assign rd_data      = rd_data_q;
   assign overflow     = overflow_q;
   assign pending_ints = pend_q;
endmodule

// File: tb/tb_reg_write_sink.sv
// tb_reg_write_sink: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_reg_write_sink;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst, in_reg_stb, dev_ready, in_reg_busy, dev_valid, overflow;
   logic [5:0] in_reg_addr, rd_addr, dev_addr;
   logic [31:0] in_reg_data, in_clear_ints, int_set, pending_ints, dev_data, rd_data;
   logic [37:0] m_q[$];
   logic [31:0] m_shadow [64];
   logic [31:0] m_rd, m_pend;
   logic m_busy, m_ovf;
   int n_chk = 0, n_fail = 0;

   reg_write_sink #(.FIFO_DEPTH(DEPTH), .INT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_reg_addr(in_reg_addr), .in_reg_data(in_reg_data),
      .in_reg_stb(in_reg_stb), .in_reg_busy(in_reg_busy), .in_clear_ints(in_clear_ints),
      .int_set(int_set), .pending_ints(pending_ints), .dev_addr(dev_addr), .dev_data(dev_data),
      .dev_valid(dev_valid), .dev_ready(dev_ready), .rd_addr(rd_addr), .rd_data(rd_data),
      .overflow(overflow));

   always #5 clk = ~clk;

   task automatic tick();
      logic acc;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         foreach (m_shadow[i]) m_shadow[i] = '0;
         m_rd = '0; m_busy = 1'b0; m_ovf = 1'b0; m_pend = 32'h8000_0000;
      end else begin
         acc = in_reg_stb && !m_busy;
         if (in_reg_stb && m_busy) m_ovf = 1'b1;
         m_rd = m_shadow[rd_addr];
         if (m_q.size() != 0 && dev_ready) begin
            m_shadow[m_q[0][37:32]] = m_q[0][31:0];
            void'(m_q.pop_front());
         end
         if (acc) m_q.push_back({in_reg_addr, in_reg_data});
         m_busy = (m_q.size() == DEPTH);
         m_pend = (((m_pend & ~in_clear_ints) | int_set) & 32'h7FFF_FFFF) | ((m_q.size() == 0) ? 32'h8000_0000 : 32'h0);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_reg_stb = 0; dev_ready = 0; in_reg_addr = 0; in_reg_data = 0;
      in_clear_ints = 0; int_set = 0; rd_addr = 0;
      tick(); tick();
      rst = 1'b0;
      n_chk++; if (dev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", dev_valid); end
      n_chk++; if (in_reg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", in_reg_busy); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      n_chk++; if (pending_ints !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pending got=%h exp=80000000", pending_ints); end
      n_chk++; if ({dev_addr, dev_data, rd_data} !== '0) begin n_fail++; $display("FAIL reset_dev_rd got=%h/%h/%h exp=0", dev_addr, dev_data, rd_data); end
   endtask

   task automatic test_single();
      dev_ready = 1; in_reg_stb = 1; in_reg_addr = 6'd5; in_reg_data = 32'hDEAD_BEEF;
      tick();
      in_reg_stb = 0;
      n_chk++; if ({dev_valid, dev_addr, dev_data} !== {1'b1, 6'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL single_present got=%0b/%0d/%h exp=1/5/deadbeef", dev_valid, dev_addr, dev_data); end
      n_chk++; if (pending_ints[31] !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle got=%0b exp=0", pending_ints[31]); end
      tick();
      n_chk++; if ({dev_valid, pending_ints[31]} !== 2'b01) begin n_fail++; $display("FAIL single_drain got=%b exp=01", {dev_valid, pending_ints[31]}); end
      rd_addr = 6'd5;
      tick();
      n_chk++; if (rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_readback got=%h exp=deadbeef", rd_data); end
   endtask

   task automatic test_full_overflow();
      dev_ready = 0;
      for (int i = 0; i < 4; i++) begin
         in_reg_stb = 1; in_reg_addr = 6'(10 + i); in_reg_data = 32'h100 + i;
         tick();
      end
      n_chk++; if (in_reg_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got=%0b exp=1", in_reg_busy); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got=%0b exp=0", overflow); end
      in_reg_data = 32'h999;
      tick();
      n_chk++; if ({overflow, in_reg_busy} !== 2'b11) begin n_fail++; $display("FAIL full_ovf got=%b exp=11", {overflow, in_reg_busy}); end
      in_reg_stb = 0; dev_ready = 1;
      for (int k = 0; k < 4; k++) begin
         n_chk++; if ({dev_valid, dev_addr, dev_data} !== {1'b1, 6'(10 + k), 32'h100 + k}) begin n_fail++; $display("FAIL full_drain%0d got=%0b/%0d/%h exp=1/%0d/%h", k, dev_valid, dev_addr, dev_data, 10 + k, 32'h100 + k); end
         tick();
         if (k == 0) begin
            n_chk++; if (in_reg_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_release got=%0b exp=0", in_reg_busy); end
         end
      end
      n_chk++; if (dev_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0b exp=0", dev_valid); end
   endtask

   task automatic test_streaming();
      dev_ready = 1;
      for (int i = 0; i < 10; i++) begin
         in_reg_stb = 1; in_reg_addr = 6'(20 + i); in_reg_data = 32'h200 + i;
         tick();
         n_chk++; if ({dev_valid, in_reg_busy, dev_data} !== {1'b1, 1'b0, 32'h200 + i}) begin n_fail++; $display("FAIL stream%0d got=%0b/%0b/%h exp=1/0/%h", i, dev_valid, in_reg_busy, dev_data, 32'h200 + i); end
      end
      in_reg_stb = 0;
      tick();
      n_chk++; if (dev_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got=%0b exp=0", dev_valid); end
   endtask

   task automatic test_ints();
      int_set = 32'h1; in_clear_ints = 32'h1;
      tick();
      n_chk++; if (pending_ints[0] !== 1'b1) begin n_fail++; $display("FAIL int_set_wins got=%0b exp=1", pending_ints[0]); end
      int_set = 0;
      tick();
      n_chk++; if (pending_ints[0] !== 1'b0) begin n_fail++; $display("FAIL int_clear got=%0b exp=0", pending_ints[0]); end
      in_clear_ints = 32'hFFFF_FFFF;
      tick();
      n_chk++; if (pending_ints !== 32'h8000_0000) begin n_fail++; $display("FAIL int_idle_noclear got=%h exp=80000000", pending_ints); end
      in_clear_ints = 0;
   endtask

   task automatic test_reset_midflight();
      dev_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_reg_stb = 1; in_reg_addr = 6'(40 + i); in_reg_data = 32'hA00 + i;
         tick();
      end
      n_chk++; if (dev_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got=%0b exp=1", dev_valid); end
      rst = 1; dev_ready = 1; int_set = 32'h3;
      tick();
      rst = 0; in_reg_stb = 0; dev_ready = 0; int_set = 0;
      n_chk++; if ({dev_valid, in_reg_busy, overflow} !== 3'b000) begin n_fail++; $display("FAIL mid_reset got=%b exp=000", {dev_valid, in_reg_busy, overflow}); end
      n_chk++; if (pending_ints !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_pending got=%h exp=80000000", pending_ints); end
      rd_addr = 6'd40;
      tick(); tick();
      n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_shadow got=%h exp=0", rd_data); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         in_reg_stb = $urandom_range(0, 1);
         in_reg_addr = 6'($urandom);
         in_reg_data = $urandom;
         dev_ready = ($urandom_range(0, 9) < 6);
         rd_addr = 6'($urandom_range(0, 7)) + 6'd8 * 6'($urandom_range(0, 1));
         int_set = $urandom & $urandom & $urandom;
         in_clear_ints = $urandom & $urandom;
         if (c % 10 == 0) in_reg_addr = 6'($urandom_range(0, 15));
         tick();
         n_chk++; if (dev_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, dev_valid, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            n_chk++; if ({dev_addr, dev_data} !== m_q[0]) begin n_fail++; $display("FAIL rnd_head c=%0d got=%0d/%h exp=%0d/%h", c, dev_addr, dev_data, m_q[0][37:32], m_q[0][31:0]); end
         end
         n_chk++; if (in_reg_busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, in_reg_busy, m_busy); end
         n_chk++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
         n_chk++; if (pending_ints !== m_pend) begin n_fail++; $display("FAIL rnd_pending c=%0d got=%h exp=%h", c, pending_ints, m_pend); end
         n_chk++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL rnd_rddata c=%0d got=%h exp=%h", c, rd_data, m_rd); end
      end
      rst = 0; in_reg_stb = 0; int_set = 0; in_clear_ints = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_overflow();
      test_streaming();
      test_ints();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
